// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the bit-serial adder/subtractor controller.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter only needs to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/adder_intf.sv
// Connection bundle between the serial controller and its 1-bit full-adder slice.
interface adder_intf;
    logic a;
    logic b;
    logic cin;
    logic s;
    logic c;

    modport tb  (output a, output b, output cin, input s, input c);
    modport dut (input a, input b, input cin, output s, output c);
endinterface

// File: rtl/serial_add_ctrl_fa.sv
// Single-bit full-adder slice; purely combinational, zero latency, no backpressure.
module serial_add_ctrl_fa (
    adder_intf.dut bus
);
    assign bus.s = bus.a ^ bus.b ^ bus.cin;
    assign bus.c = (bus.a & bus.b) | (bus.a & bus.cin) | (bus.b & bus.cin);
endmodule

// File: rtl/serial_add_ctrl.sv
// WIDTH-bit add/subtract through one full-adder slice, one bit per clock, LSB first.
// Result valid WIDTH edges after accept; result is held in DONE until out_ready.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CW-1:0]    bit_cnt;
    logic             last_bit;

    adder_intf fa_if ();

    serial_add_ctrl_fa u_fa (
        .bus (fa_if.dut)
    );

    // Slice inputs are forced to zero outside RUN so nothing toggles while idle.
    always_comb begin
        fa_if.a   = 1'b0;
        fa_if.b   = 1'b0;
        fa_if.cin = 1'b0;
        if (state == RUN) begin
            fa_if.a   = a_sh[0];
            fa_if.b   = b_sh[0];
            fa_if.cin = carry;
        end
    end

    assign last_bit = (bit_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            carry   <= 1'b0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract is A + ~B + 1, so cin is replaced by the +1.
                        a_sh    <= op_a;
                        b_sh    <= sub ? ~op_b : op_b;
                        carry   <= sub ? 1'b1 : cin;
                        bit_cnt <= '0;
                        sum_sh  <= '0;
                    end
                end
                RUN: begin
                    sum_sh <= {fa_if.s, sum_sh[WIDTH-1:1]};
                    carry  <= fa_if.c;
                    a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                    if (!last_bit) begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    // Partial sums never leak onto the result port.
    assign sum       = out_valid ? sum_sh : '0;
    assign cout      = out_valid ? carry : 1'b0;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;
    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       cin;
    logic       sub;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;
    logic       busy;

    int tests_run;
    int fails;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Issues one request and returns the edges counted from accept to out_valid (99 on timeout).
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                          input logic sb, input bit release_res,
                          output logic [7:0] s, output logic co, output int lat);
        int guard;
        op_a = a; op_b = b; cin = ci; sub = sb; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!out_valid && lat < 50);
        if (!out_valid) lat = 99;
        s = sum; co = cout;
        if (release_res) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;
        #12;
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_ctrl: valid=%b busy=%b ready=%b, want 0 0 1", out_valid, busy, in_ready);
        end
        tests_run++;
        if (sum !== 8'h00 || cout !== 1'b0) begin
            fails++; $display("FAIL reset_data: sum=%h cout=%b, want 00 0", sum, cout);
        end
        @(posedge clk); #3; rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        logic [7:0] s; logic co; int lat;
        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1, s, co, lat);
        tests_run++;
        if (lat !== 8) begin fails++; $display("FAIL add_latency: got %0d, want 8", lat); end
        tests_run++;
        if (s !== 8'h96 || co !== 1'b0) begin fails++; $display("FAIL add_5a_3c: got %h/%b, want 96/0", s, co); end
    endtask

    task automatic test_carry();
        logic [7:0] s; logic co; int lat;
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, s, co, lat);
        tests_run++;
        if (s !== 8'h00 || co !== 1'b1 || lat !== 8) begin
            fails++; $display("FAIL carry_ff_01: got %h/%b lat %0d, want 00/1 lat 8", s, co, lat);
        end
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, s, co, lat);
        tests_run++;
        if (s !== 8'hFF || co !== 1'b1 || lat !== 8) begin
            fails++; $display("FAIL carry_ff_ff_c1: got %h/%b lat %0d, want ff/1 lat 8", s, co, lat);
        end
    endtask

    task automatic test_sub();
        logic [7:0] s; logic co; int lat;
        for (int ci = 0; ci < 2; ci++) begin
            run_op(8'h10, 8'h01, ci[0], 1'b1, 1'b1, s, co, lat);
            tests_run++;
            if (s !== 8'h0F || co !== 1'b1 || lat !== 8) begin
                fails++; $display("FAIL sub_10_01 cin=%0d: got %h/%b lat %0d, want 0f/1 lat 8", ci, s, co, lat);
            end
            run_op(8'h01, 8'h02, ci[0], 1'b1, 1'b1, s, co, lat);
            tests_run++;
            if (s !== 8'hFF || co !== 1'b0 || lat !== 8) begin
                fails++; $display("FAIL sub_01_02 cin=%0d: got %h/%b lat %0d, want ff/0 lat 8", ci, s, co, lat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] s; logic co; int lat;
        run_op(8'h22, 8'h11, 1'b0, 1'b0, 1'b0, s, co, lat);
        tests_run++;
        if (s !== 8'h33 || co !== 1'b0 || lat !== 8) begin
            fails++; $display("FAIL bp_result: got %h/%b lat %0d, want 33/0 lat 8", s, co, lat);
        end
        op_a = 8'hFF; op_b = 8'hFF; cin = 1'b1; sub = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if (out_valid !== 1'b1 || sum !== 8'h33 || cout !== 1'b0 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold cyc %0d: valid=%b sum=%h cout=%b ready=%b, want 1 33 0 0",
                         i, out_valid, sum, cout, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL bp_release: valid=%b busy=%b ready=%b, want 0 0 1", out_valid, busy, in_ready);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [7:0] s; logic co; int lat;
        op_a = 8'h5A; op_b = 8'h3C; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        tests_run++;
        if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy: got %b, want 1", busy); end
        rst = 1'b1;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || sum !== 8'h00 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset: valid=%b busy=%b sum=%h ready=%b, want 0 0 00 1", out_valid, busy, sum, in_ready);
        end
        @(posedge clk); #3; rst = 1'b0;
        @(posedge clk); #1;
        run_op(8'h03, 8'h04, 1'b0, 1'b0, 1'b1, s, co, lat);
        tests_run++;
        if (s !== 8'h07 || co !== 1'b0 || lat !== 8) begin
            fails++; $display("FAIL mid_after: got %h/%b lat %0d, want 07/0 lat 8", s, co, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] va [4] = '{8'h01, 8'h80, 8'h05, 8'hAA};
        logic [7:0] vb [4] = '{8'h02, 8'h80, 8'h07, 8'h55};
        logic       vc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic       vs [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [7:0] es [4] = '{8'h03, 8'h00, 8'hFE, 8'h00};
        logic       ec [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        int         acc_cyc [4];
        logic [7:0] got_s [4];
        logic       got_c [4];
        int n_acc, n_res, cyc;
        bit pend;
        n_acc = 0; n_res = 0; cyc = 0;
        op_a = va[0]; op_b = vb[0]; cin = vc[0]; sub = vs[0];
        in_valid = 1'b1; out_ready = 1'b1;
        pend = in_ready;
        while ((n_res < 4) && (cyc < 200)) begin
            @(posedge clk); #1; cyc++;
            if (pend) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                if (n_acc < 4) begin
                    op_a = va[n_acc]; op_b = vb[n_acc]; cin = vc[n_acc]; sub = vs[n_acc];
                end
            end
            if (out_valid) begin
                got_s[n_res] = sum; got_c[n_res] = cout;
                n_res++;
            end
            pend = in_ready && in_valid && (n_acc < 4);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        tests_run++;
        if (n_res !== 4 || n_acc !== 4) begin
            fails++; $display("FAIL b2b_count: accepts %0d results %0d, want 4 4", n_acc, n_res);
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (got_s[i] !== es[i] || got_c[i] !== ec[i]) begin
                    fails++; $display("FAIL b2b_result %0d: got %h/%b, want %h/%b", i, got_s[i], got_c[i], es[i], ec[i]);
                end
            end
            for (int i = 1; i < 4; i++) begin
                tests_run++;
                if (acc_cyc[i] - acc_cyc[i-1] !== 10) begin
                    fails++; $display("FAIL b2b_spacing %0d: got %0d, want 10", i, acc_cyc[i] - acc_cyc[i-1]);
                end
            end
        end
    endtask

    initial begin
        tests_run = 0;
        fails     = 0;
        test_reset();
        test_add();
        test_carry();
        test_sub();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
